// File: rtl/holy_uart_pkg.sv
// holy_uart_tx_lite shared definitions.
// Register offsets, bit indices, FSM state types and AXI responses.
package holy_uart_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_BAUD   = 4'hC;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 8;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    // A zero divider would never end a bit, so it is treated as one.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// 32-bit AXI-lite bundle between the crossbar and its slaves.
// The slave modport is the register-file side.
interface axi_lite_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/holy_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Push when full and pop when empty are ignored.
module holy_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/holy_uart_tx_lite.sv
// AXI-lite UART transmitter: register file, TX FIFO and 8N1 serializer.
// tx_irq is a registered level that is high while the FIFO has drained.
module holy_uart_tx_lite
    import holy_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_E000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic      clk,
    input  logic      rst,
    axi_lite_if.slave s_axi_lite,
    output logic      uart_tx,
    output logic      tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_t   w_state;
    wr_state_t   w_next;
    rd_state_t   r_state;
    rd_state_t   r_next;
    tx_state_t   tx_state;
    tx_state_t   tx_next;

    logic [31:0] w_off;
    logic [31:0] r_off;
    logic        w_mapped;
    logic        r_mapped;
    logic        wr_fire;
    logic        rd_fire;
    logic        ar_rdy;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [31:0] rd_val;
    logic [31:0] status_w;

    logic [1:0]  ctrl_q;
    logic [15:0] baud_q;
    logic        ovf_q;
    logic        irq_q;

    logic        sel_tx;
    logic        sel_status;
    logic        sel_ctrl;
    logic        sel_baud;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [15:0] div_q;
    logic [15:0] div_n;
    logic [15:0] cnt_q;
    logic [15:0] cnt_n;
    logic [2:0]  bit_q;
    logic [2:0]  bit_n;
    logic [7:0]  sh_q;
    logic [7:0]  sh_n;
    logic        tx_q;
    logic        tx_n;
    logic        bit_end;
    logic        busy;
    logic        tx_en;

    logic        unused_bits;
    assign unused_bits = ^{s_axi_lite.wdata[31:16], s_axi_lite.wstrb[3:2]};

    assign w_off    = s_axi_lite.awaddr - BASE_ADDR;
    assign r_off    = s_axi_lite.araddr - BASE_ADDR;
    assign w_mapped = (w_off[31:4] == '0);
    assign r_mapped = (r_off[31:4] == '0);

    assign sel_tx     = w_mapped & (w_off[3:0] == OFF_TXDATA);
    assign sel_status = w_mapped & (w_off[3:0] == OFF_STATUS);
    assign sel_ctrl   = w_mapped & (w_off[3:0] == OFF_CTRL);
    assign sel_baud   = w_mapped & (w_off[3:0] == OFF_BAUD);

    assign busy      = (tx_state != IDLE);
    assign tx_en     = ctrl_q[CTRL_TX_EN];
    assign fifo_push = wr_fire & sel_tx & s_axi_lite.wstrb[0];

    // ---------------- write channel ----------------
    always_comb begin
        w_next                = w_state;
        wr_fire               = 1'b0;
        s_axi_lite.awready    = 1'b0;
        s_axi_lite.wready     = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (s_axi_lite.awvalid && s_axi_lite.wvalid) begin
                    s_axi_lite.awready = 1'b1;
                    s_axi_lite.wready  = 1'b1;
                    wr_fire            = 1'b1;
                    w_next             = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_lite.bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign s_axi_lite.bvalid = (w_state == W_RESP);
    assign s_axi_lite.bresp  = bresp_q;

    // ---------------- read channel ----------------
    assign rd_fire = ar_rdy & s_axi_lite.arvalid;

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (rd_fire) r_next = R_RESP;
            R_RESP:  if (s_axi_lite.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign s_axi_lite.arready = ar_rdy;
    assign s_axi_lite.rvalid  = (r_state == R_RESP);
    assign s_axi_lite.rdata   = rdata_q;
    assign s_axi_lite.rresp   = rresp_q;

    always_comb begin
        status_w                   = '0;
        status_w[ST_FULL]          = fifo_full;
        status_w[ST_EMPTY]         = fifo_empty;
        status_w[ST_BUSY]          = busy;
        status_w[ST_OVF]           = ovf_q;
        status_w[ST_CNT_LO +: 4]   = 4'(fifo_count);
    end

    always_comb begin
        rd_val = '0;
        if (r_mapped) begin
            unique case (1'b1)
                (r_off[3:0] == OFF_STATUS): rd_val = status_w;
                (r_off[3:0] == OFF_CTRL):   rd_val = {30'b0, ctrl_q};
                (r_off[3:0] == OFF_BAUD):   rd_val = {16'b0, baud_q};
                default:                    rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            ar_rdy  <= 1'b0;
            bresp_q <= OKAY;
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            ar_rdy  <= (r_next == R_IDLE);
            if (wr_fire) begin
                bresp_q <= w_mapped ? OKAY : SLVERR;
            end
            if (rd_fire) begin
                rdata_q <= rd_val;
                rresp_q <= r_mapped ? OKAY : SLVERR;
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            baud_q <= DEFAULT_DIV;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_fire && sel_ctrl && s_axi_lite.wstrb[0]) begin
                ctrl_q <= s_axi_lite.wdata[1:0];
            end
            if (wr_fire && sel_baud && s_axi_lite.wstrb[0]) begin
                baud_q[7:0] <= s_axi_lite.wdata[7:0];
            end
            if (wr_fire && sel_baud && s_axi_lite.wstrb[1]) begin
                baud_q[15:8] <= s_axi_lite.wdata[15:8];
            end
            if (wr_fire && sel_status && s_axi_lite.wstrb[0]
                && s_axi_lite.wdata[ST_OVF]) begin
                ovf_q <= 1'b0;
            end
            if (fifo_push && fifo_full) begin
                ovf_q <= 1'b1;
            end
            irq_q <= ctrl_q[CTRL_IRQ_EN] & fifo_empty & ~busy;
        end
    end

    assign tx_irq = irq_q;

    holy_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (s_axi_lite.wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- serializer ----------------
    assign bit_end = (cnt_q == div_q - 16'd1);

    always_comb begin
        tx_next  = tx_state;
        div_n    = div_q;
        cnt_n    = cnt_q;
        bit_n    = bit_q;
        sh_n     = sh_q;
        fifo_pop = 1'b0;
        unique case (tx_state)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_n     = fifo_dout;
                    div_n    = clamp_div(baud_q);
                    cnt_n    = '0;
                    tx_next  = START;
                end
            end
            START: begin
                cnt_n = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    tx_next = DATA;
                end
            end
            DATA: begin
                cnt_n = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_n = '0;
                    sh_n  = {1'b0, sh_q[7:1]};
                    bit_n = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        tx_next = STOP;
                    end
                end
            end
            STOP: begin
                cnt_n = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_n   = '0;
                    tx_next = IDLE;
                    // Chain the next frame straight out of the stop bit.
                    if (tx_en && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_n     = fifo_dout;
                        div_n    = clamp_div(baud_q);
                        tx_next  = START;
                    end
                end
            end
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        tx_n = 1'b1;
        unique case (tx_next)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            div_q    <= 16'd1;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_next;
            div_q    <= div_n;
            cnt_q    <= cnt_n;
            bit_q    <= bit_n;
            sh_q     <= sh_n;
            tx_q     <= tx_n;
        end
    end

    assign uart_tx = tx_q;

endmodule

// File: tb/tb_holy_uart_tx_lite.sv
// Directed bench for holy_uart_tx_lite.
// Inputs change on negedge / after posedge; outputs sampled on negedge.
module tb_holy_uart_tx_lite;

    localparam logic [31:0] BASE = 32'h0000_E000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx;
    logic tx_irq;
    int   cmp = 0;
    int   bad = 0;

    axi_lite_if bus ();

    holy_uart_tx_lite dut (
        .clk        (clk),
        .rst        (rst),
        .s_axi_lite (bus),
        .uart_tx    (uart_tx),
        .tx_irq     (tx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        #1;
        n = 0;
        while (!bus.awready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.awready) begin
            cmp++; bad++;
            $display("FAIL wr_accept_timeout addr=%h", addr);
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.bvalid) begin
            cmp++; bad++;
            $display("FAIL wr_bvalid_timeout addr=%h", addr);
        end
        resp = bus.bresp;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.arready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.arready) begin
            cmp++; bad++;
            $display("FAIL rd_accept_timeout addr=%h", addr);
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.rvalid) begin
            cmp++; bad++;
            $display("FAIL rd_rvalid_timeout addr=%h", addr);
        end
        data = bus.rdata;
        resp = bus.rresp;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    // Returns on the negedge of the first low (start) sample.
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (uart_tx && n < 200) begin
            @(negedge clk); n++;
        end
        if (uart_tx) begin
            cmp++; bad++;
            $display("FAIL %s start_timeout", tag);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk);
        cmp++;
        if ({uart_tx, tx_irq} !== 2'b10) begin
            bad++;
            $display("FAIL rst_pins got=%b exp=10", {uart_tx, tx_irq});
        end
        cmp++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL rst_axi got=%b exp=00000",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid});
        end
        @(negedge clk);
        rst = 1'b0;
        axi_rd(BASE + 32'h4, d, r);
        cmp++;
        if (d !== 32'h2) begin
            bad++; $display("FAIL rst_status got=%h exp=%h", d, 32'h2);
        end
        axi_rd(BASE + 32'hC, d, r);
        cmp++;
        if (d !== 32'd868) begin
            bad++; $display("FAIL rst_baud got=%0d exp=868", d);
        end
        axi_rd(BASE + 32'h8, d, r);
        cmp++;
        if ({r, d} !== 34'h0) begin
            bad++; $display("FAIL rst_ctrl got=%h/%b exp=0/00", d, r);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        logic [1:0]  r;
        axi_rd(BASE + 32'h10, d, r);
        cmp++;
        if ({r, d} !== {2'b10, 32'h0}) begin
            bad++; $display("FAIL unmapped_rd got=%b/%h exp=10/0", r, d);
        end
        axi_wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, r);
        cmp++;
        if (r !== 2'b10) begin
            bad++; $display("FAIL unmapped_wr_bresp got=%b exp=10", r);
        end
        axi_rd(BASE + 32'h8, d, r);
        cmp++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL unmapped_wr_ctrl got=%h exp=0", d);
        end
        axi_rd(BASE + 32'h0, d, r);
        cmp++;
        if ({r, d} !== 34'h0) begin
            bad++; $display("FAIL txdata_rd got=%b/%h exp=00/0", r, d);
        end
        axi_wr(BASE + 32'hC, 32'h0000_AB00, 4'b0010, r);
        cmp++;
        if (r !== 2'b00) begin
            bad++; $display("FAIL baud_wr_bresp got=%b exp=00", r);
        end
        axi_rd(BASE + 32'hC, d, r);
        cmp++;
        if (d !== 32'h0000_AB64) begin
            bad++; $display("FAIL baud_strb got=%h exp=%h", d, 32'hAB64);
        end
        axi_wr(BASE + 32'h8, 32'h3, 4'b1110, r);
        axi_wr(BASE + 32'h0, 32'h41, 4'b1110, r);
        axi_rd(BASE + 32'h8, d, r);
        cmp++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL ctrl_strb got=%h exp=0", d);
        end
        axi_rd(BASE + 32'h4, d, r);
        cmp++;
        if (d !== 32'h2) begin
            bad++; $display("FAIL txdata_nostrb got=%h exp=2", d);
        end
    endtask

    task automatic test_frame();
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  byt;
        logic        e;
        byt = 8'h55;
        axi_wr(BASE + 32'hC, 32'd4, 4'hF, r);
        axi_wr(BASE + 32'h8, 32'h1, 4'hF, r);
        axi_wr(BASE + 32'h0, {24'b0, byt}, 4'hF, r);
        fork
            begin
                wait_start("frame");
                for (int i = 0; i < 41; i++) begin
                    if (i > 0) @(negedge clk);
                    e = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : byt[(i / 4) - 1];
                    cmp++;
                    if (uart_tx !== e) begin
                        bad++;
                        $display("FAIL frame_bit cyc=%0d got=%b exp=%b", i, uart_tx, e);
                    end
                end
            end
            begin
                repeat (10) @(negedge clk);
                axi_rd(BASE + 32'h4, d, r);
                cmp++;
                if (d[2] !== 1'b1) begin
                    bad++; $display("FAIL frame_busy got=%b exp=1", d[2]);
                end
            end
        join
        axi_rd(BASE + 32'h4, d, r);
        cmp++;
        if (d !== 32'h2) begin
            bad++; $display("FAIL frame_done_status got=%h exp=2", d);
        end
    endtask

    task automatic test_overflow_drain();
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  byt;
        logic        e;
        int          b;
        axi_wr(BASE + 32'h8, 32'h0, 4'hF, r);
        axi_wr(BASE + 32'hC, 32'd2, 4'hF, r);
        for (int k = 0; k < 9; k++) begin
            axi_wr(BASE + 32'h0, 32'hA0 + k, 4'hF, r);
        end
        axi_rd(BASE + 32'h4, d, r);
        cmp++;
        if (d !== 32'h809) begin
            bad++; $display("FAIL ovf_status got=%h exp=809", d);
        end
        axi_wr(BASE + 32'h4, 32'h8, 4'hF, r);
        axi_rd(BASE + 32'h4, d, r);
        cmp++;
        if (d !== 32'h801) begin
            bad++; $display("FAIL ovf_clear got=%h exp=801", d);
        end
        axi_wr(BASE + 32'h8, 32'h1, 4'hF, r);
        wait_start("drain");
        for (int i = 0; i < 161; i++) begin
            if (i > 0) @(negedge clk);
            byt = 8'hA0 + 8'(i / 20);
            b   = (i % 20) / 2;
            e   = (i >= 160) ? 1'b1 : (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byt[b - 1];
            cmp++;
            if (uart_tx !== e) begin
                bad++;
                $display("FAIL drain_bit cyc=%0d got=%b exp=%b", i, uart_tx, e);
            end
        end
        axi_rd(BASE + 32'h4, d, r);
        cmp++;
        if (d !== 32'h2) begin
            bad++; $display("FAIL drain_status got=%h exp=2", d);
        end
    endtask

    task automatic test_irq();
        logic [1:0] r;
        axi_wr(BASE + 32'hC, 32'd2, 4'hF, r);
        axi_wr(BASE + 32'h8, 32'h3, 4'hF, r);
        @(negedge clk);
        cmp++;
        if (tx_irq !== 1'b1) begin
            bad++; $display("FAIL irq_empty got=%b exp=1", tx_irq);
        end
        axi_wr(BASE + 32'h0, 32'h3C, 4'hF, r);
        wait_start("irq");
        for (int i = 0; i < 22; i++) begin
            if (i > 0) @(negedge clk);
            cmp++;
            if (tx_irq !== (i == 21)) begin
                bad++;
                $display("FAIL irq_frame cyc=%0d got=%b exp=%b", i, tx_irq, i == 21);
            end
        end
        axi_wr(BASE + 32'h8, 32'h1, 4'hF, r);
        cmp++;
        if (tx_irq !== 1'b0) begin
            bad++; $display("FAIL irq_disable got=%b exp=0", tx_irq);
        end
    endtask

    task automatic test_handshake();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk);
        bus.awaddr  = BASE + 32'hC;
        bus.wdata   = 32'd16;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp++;
            if ({bus.awready, bus.wready} !== 2'b00) begin
                bad++;
                $display("FAIL aw_early cyc=%0d got=%b exp=00", i, {bus.awready, bus.wready});
            end
            @(negedge clk);
        end
        bus.wvalid = 1'b1;
        #1;
        cmp++;
        if ({bus.awready, bus.wready} !== 2'b11) begin
            bad++;
            $display("FAIL aw_w_join got=%b exp=11", {bus.awready, bus.wready});
        end
        @(posedge clk); #1;
        bus.wdata = 32'd32;
        for (int i = 0; i < 5; i++) begin
            cmp++;
            if ({bus.bvalid, bus.awready} !== 2'b10) begin
                bad++;
                $display("FAIL b_hold cyc=%0d got=%b exp=10", i, {bus.bvalid, bus.awready});
            end
            @(posedge clk); #1;
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        cmp++;
        if (bus.awready !== 1'b1) begin
            bad++; $display("FAIL aw_second got=%b exp=1", bus.awready);
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        axi_rd(BASE + 32'hC, d, r);
        cmp++;
        if (d !== 32'd32) begin
            bad++; $display("FAIL second_wr_baud got=%0d exp=32", d);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic [1:0]  r;
        axi_wr(BASE + 32'h8, 32'h0, 4'hF, r);
        axi_wr(BASE + 32'hC, 32'd4, 4'hF, r);
        axi_wr(BASE + 32'h0, 32'h00, 4'hF, r);
        axi_wr(BASE + 32'h0, 32'h11, 4'hF, r);
        axi_wr(BASE + 32'h8, 32'h1, 4'hF, r);
        wait_start("rstmid");
        repeat (15) @(negedge clk);
        cmp++;
        if (uart_tx !== 1'b0) begin
            bad++; $display("FAIL rstmid_pre got=%b exp=0", uart_tx);
        end
        rst = 1'b1;
        #1;
        cmp++;
        if (uart_tx !== 1'b1) begin
            bad++; $display("FAIL rstmid_async got=%b exp=1", uart_tx);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        axi_rd(BASE + 32'h4, d, r);
        cmp++;
        if (d !== 32'h2) begin
            bad++; $display("FAIL rstmid_status got=%h exp=2", d);
        end
        axi_rd(BASE + 32'hC, d, r);
        cmp++;
        if (d !== 32'd868) begin
            bad++; $display("FAIL rstmid_baud got=%0d exp=868", d);
        end
        cmp++;
        if (uart_tx !== 1'b1) begin
            bad++; $display("FAIL rstmid_idle got=%b exp=1", uart_tx);
        end
    endtask

    initial begin
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        test_reset();
        test_regs();
        test_frame();
        test_overflow_drain();
        test_irq();
        test_handshake();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
